conv3d_frame_sched: RTL

Frame-level scheduler in front of the conv3d datapath.
- Accepts one frame descriptor (height, width, stride) per frame over a valid/ready handshake.
- Validates the descriptor and computes the expected output count by sequential ceil-division.
- Holds frame_h/frame_w/stride stable for the whole frame and issues the frame_start pulse.
- Gates the upstream pixel stream into the datapath's valid-only input, counts returned dout_vld beats and reports frame completion or errors.

---
 rtl/conv_sched_pkg.sv | 22 ++
 rtl/conv3d_frame_sched_div.sv | 35 +++
 rtl/conv3d_frame_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and widths for the conv3d frame scheduler.
package conv_sched_pkg;
    localparam int FRAME_H_MAX_D = 224;
    localparam int FRAME_W_MAX_D = 224;
    localparam int STRIDE_MAX_D  = 4;
    localparam int DIN_WIDTH_D   = 8;
    localparam int CHANNELS_IN_D = 4;

    localparam int H_W   = $clog2(FRAME_H_MAX_D) + 1;
    localparam int W_W   = $clog2(FRAME_W_MAX_D) + 1;
    localparam int S_W   = $clog2(STRIDE_MAX_D) + 1;
    localparam int PIX_W = DIN_WIDTH_D * CHANNELS_IN_D;
    localparam int CNT_W = $clog2(FRAME_H_MAX_D * FRAME_W_MAX_D) + 1;

    typedef enum logic [2:0] {IDLE, CALC, START, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [H_W-1:0] h;
        logic [W_W-1:0] w;
        logic [S_W-1:0] stride;
    } cfg_t;
endpackage

// File: rtl/conv3d_frame_sched_div.sv
// Sequential ceil(n/d): one add of d per cycle until the accumulator reaches n.
module seq_ceil_div
    import conv_sched_pkg::*;
#(
    parameter int N_W = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [S_W-1:0] d,
    output logic [N_W-1:0] q,
    output logic           done
);
    logic [N_W:0] acc;
    logic         run;

    // n and d are sampled while running, so they must be stable from the cycle after start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            q   <= '0;
            run <= 1'b0;
        end else if (start) begin
            acc <= '0;
            q   <= '0;
            run <= 1'b1;
        end else if (run && (acc < {1'b0, n})) begin
            acc <= acc + (N_W+1)'(d);
            q   <= q + 1'b1;
        end
    end

    assign done = run && (acc >= {1'b0, n});
endmodule

// File: rtl/conv3d_frame_sched.sv
// Frame scheduler: validates a descriptor, sizes the frame, gates pixels in and counts results out.
module conv3d_frame_sched
    import conv_sched_pkg::*;
#(
    parameter int FRAME_H_MAX   = FRAME_H_MAX_D,
    parameter int FRAME_W_MAX   = FRAME_W_MAX_D,
    parameter int STRIDE_MAX    = STRIDE_MAX_D,
    parameter int DIN_WIDTH     = DIN_WIDTH_D,
    parameter int CHANNELS_IN   = CHANNELS_IN_D,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cfg_vld,
    output logic                            cfg_rdy,
    input  logic [H_W-1:0]                  cfg_frame_h,
    input  logic [W_W-1:0]                  cfg_frame_w,
    input  logic [S_W-1:0]                  cfg_stride,
    input  logic                            s_vld,
    output logic                            s_rdy,
    input  logic [CHANNELS_IN*DIN_WIDTH-1:0] s_data,
    output logic [H_W-1:0]                  frame_h,
    output logic [W_W-1:0]                  frame_w,
    output logic [S_W-1:0]                  stride,
    output logic                            frame_start,
    output logic                            din_vld,
    output logic [CHANNELS_IN*DIN_WIDTH-1:0] din,
    input  logic                            dout_vld,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err_cfg,
    output logic                            err_timeout,
    output logic                            err_spurious
);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT) + 1;

    state_t           state, state_n;
    cfg_t             cfg_q;
    logic             rdy_en;
    logic [CNT_W-1:0] in_cnt, in_total, out_cnt, out_total;
    logic [TMO_W-1:0] tmo;
    logic [H_W-1:0]   q_h;
    logic [W_W-1:0]   q_w;
    logic             done_h, done_w;
    logic             cfg_hs, cfg_ok, s_hs, out_full, dout_take, calc_fin;

    assign cfg_ok = (cfg_frame_h >= H_W'(1)) && (cfg_frame_h <= H_W'(FRAME_H_MAX)) &&
                    (cfg_frame_w >= W_W'(1)) && (cfg_frame_w <= W_W'(FRAME_W_MAX)) &&
                    (cfg_stride  >= S_W'(1)) && (cfg_stride  <= S_W'(STRIDE_MAX));
    // rdy_en keeps cfg_rdy low while reset is held and for the first cycle after
    assign cfg_hs    = cfg_vld && rdy_en && (state == IDLE);
    assign s_hs      = s_vld && (state == STREAM) && (in_cnt < in_total);
    assign out_full  = (out_cnt == out_total);
    assign dout_take = dout_vld && ((state == STREAM) || (state == DRAIN)) && !out_full;
    assign calc_fin  = (state == CALC) && done_h && done_w;

    assign cfg_rdy     = rdy_en && (state == IDLE);
    assign s_rdy       = (state == STREAM) && (in_cnt < in_total);
    assign frame_start = (state == START);
    assign busy        = (state != IDLE);
    assign frame_h     = cfg_q.h;
    assign frame_w     = cfg_q.w;
    assign stride      = cfg_q.stride;

    seq_ceil_div #(.N_W(H_W)) u_div_h (
        .clk(clk), .rst_n(reset_n), .start(cfg_hs && cfg_ok),
        .n(cfg_q.h), .d(cfg_q.stride), .q(q_h), .done(done_h)
    );
    seq_ceil_div #(.N_W(W_W)) u_div_w (
        .clk(clk), .rst_n(reset_n), .start(cfg_hs && cfg_ok),
        .n(cfg_q.w), .d(cfg_q.stride), .q(q_w), .done(done_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        frame_done  = 1'b0;
        err_timeout = 1'b0;
        case (state)
            IDLE:   if (cfg_hs && cfg_ok) state_n = CALC;
            CALC:   if (calc_fin) state_n = START;
            START:  state_n = STREAM;
            STREAM: if (s_hs && (in_cnt == in_total - CNT_W'(1))) state_n = DRAIN;
            DRAIN: begin
                // completion wins over a timeout landing on the same cycle
                if (out_full) begin
                    frame_done = 1'b1;
                    state_n    = IDLE;
                end else if (tmo == TMO_W'(DRAIN_TIMEOUT)) begin
                    err_timeout = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q        <= '0;
            rdy_en       <= 1'b0;
            in_cnt       <= '0;
            in_total     <= '0;
            out_cnt      <= '0;
            out_total    <= '0;
            tmo          <= '0;
            din          <= '0;
            din_vld      <= 1'b0;
            err_cfg      <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            rdy_en       <= 1'b1;
            err_cfg      <= 1'b0;
            err_spurious <= 1'b0;
            din_vld      <= s_hs;
            if (s_hs) begin
                din    <= s_data;
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (cfg_hs) begin
                if (cfg_ok) begin
                    cfg_q   <= '{h: cfg_frame_h, w: cfg_frame_w, stride: cfg_stride};
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end else begin
                    err_cfg <= 1'b1;
                end
            end
            if (calc_fin) begin
                out_total <= CNT_W'(q_h) * CNT_W'(q_w);
                in_total  <= CNT_W'(cfg_q.h) * CNT_W'(cfg_q.w);
            end
            if (dout_take)     out_cnt      <= out_cnt + CNT_W'(1);
            else if (dout_vld) err_spurious <= 1'b1;
            tmo <= ((state == DRAIN) && !dout_vld) ? tmo + TMO_W'(1) : '0;
        end
    end
endmodule
